// File: rtl/stock_window_packer.sv
// stock_window_packer: clamps raw prices into a 3-day window and emits packed {owned,day1,day2,day3} words.
// Define OWNERSHIP_TRACK_EN to take bit 15 from action codes instead of owned_in.
module stock_window_packer #(
   parameter int PRICE_W = 8,
   parameter bit SLIDING = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               price_valid,
   output logic               price_ready,
   input  logic [PRICE_W-1:0] price_in,
   input  logic               owned_in,
   input  logic               flush,
   output logic               stock_valid,
   input  logic               stock_ready,
   output logic [15:0]        stock_out,
   output logic [1:0]         fill_level
`ifdef OWNERSHIP_TRACK_EN
   ,
   input  logic               action_valid,
   input  logic [15:0]        action_in
`endif
);
   typedef enum logic [1:0] {FILL0, FILL1, FILL2, FULL} state_t;
   state_t state;
   // The oldest day is always overwritten before it is read, so only the two newest are stored.
   logic [4:0] day2, day3, d;
   logic accept, xfer, complete, own;
   state_t nxt;
   assign price_ready = !flush && (!stock_valid || stock_ready);
   assign accept = price_valid && price_ready;
   assign xfer = stock_valid && stock_ready;
   assign d = (32'(price_in) > 32'd31) ? 5'd31 : price_in[4:0];
   assign complete = accept && (state == FILL2 || (SLIDING && state == FULL));
   assign nxt = state == FILL0 ? FILL1 : state == FILL1 ? FILL2 : (SLIDING ? FULL : FILL0);
   assign fill_level = state;
`ifdef OWNERSHIP_TRACK_EN
   logic owned_q;
   assign own = owned_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         owned_q <= 1'b0;
      else if (action_valid)
         owned_q <= (action_in == 16'h1 || action_in == 16'h5) ? 1'b0 :
                    (action_in == 16'h4 || action_in == 16'h6) ? 1'b1 : owned_q;
`else
   assign own = owned_in;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL0;
         day2 <= '0;
         day3 <= '0;
         stock_valid <= 1'b0;
         stock_out <= '0;
      end else begin
         if (flush) begin
            state <= FILL0;
            day2 <= '0;
            day3 <= '0;
         end else if (accept) begin
            state <= nxt;
            day2 <= day3;
            day3 <= d;
         end
         if (complete) begin
            stock_valid <= 1'b1;
            stock_out <= {own, day2, day3, d};
         end else if (xfer)
            stock_valid <= 1'b0;
      end
   end
endmodule

// File: doc/stock_window_packer.md
Name: stock_window_packer

Overview:
Front-end producer for the trading decision logic. It accepts a stream of raw daily prices and an ownership flag. It clamps each price to 5 bits and keeps a window of the three most recent days. Each completed window is packed into the 16-bit stock word {owned, day1, day2, day3} and presented on a valid/ready output to the decision block.

Parameters:
PRICE_W, 8, width of raw price input; values above 31 saturate to 31
SLIDING, 1, 1 = overlapping window (one word per new price once filled); 0 = disjoint windows (one word per 3 prices)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
price_valid  input  1  raw price offered
price_ready  output  1  packer accepts price this cycle
price_in  input  PRICE_W  raw daily price, unsigned
owned_in  input  1  current ownership flag, sampled on the window-completing price
flush  input  1  synchronous; discard partial/current window
stock_valid  output  1  packed word available
stock_ready  input  1  consumer takes word
stock_out  output  16  [15]=owned, [14:10]=oldest day, [9:5]=middle day, [4:0]=newest day
fill_level  output  2  number of days currently held (0..3)

Behaviour:
- Reset (async, rst_n low):
  - stock_valid=0, stock_out=0, fill_level=0, window registers=0, FSM=FILL0.
  - Any pending word is lost.
- Handshakes:
  - price_ready = !flush && (!stock_valid || stock_ready), combinational.
  - A price is accepted when price_valid && price_ready.
  - An output transfer occurs when stock_valid && stock_ready.
- Clamp: d = (price_in > 31) ? 31 : price_in[4:0]. Unsigned compare on the full PRICE_W width.
- FSM states: FILL0, FILL1, FILL2, FULL.
  - FILL0 --accept--> FILL1 --accept--> FILL2 --accept--> FULL.
  - The accept in FILL2 completes a window.
  - FULL --accept--> FULL when SLIDING=1: window shifts, oldest dropped, and a new word is produced.
  - When SLIDING=0, the accept in FILL2 produces the word and goes to FILL0. FULL is unused.
- Window shift on accept: day1<=day2, day2<=day3, day3<=d.
- Word production, registered:
  - On the window-completing accept at edge N, stock_out and stock_valid=1 are visible from edge N.
  - stock_out = {owned_in, day2, day3, d} using the pre-shift values.
  - Latency: 1 cycle from accept.
- Output hold: while stock_valid && !stock_ready, stock_out is stable and price_ready=0.
- Same-cycle accept and transfer (stock_ready=1): the new word replaces the old with stock_valid staying 1. Zero bubble, full throughput.
- Transfer with no new word: stock_valid<=0 on that edge.
- flush:
  - Highest priority over price acceptance.
  - Sets FSM=FILL0, fill_level=0, day registers=0.
  - Does not affect a pending stock_valid/stock_out; that word still completes its handshake.
- fill_level mirrors the FSM: FILL0=0, FILL1=1, FILL2=2, FULL=3.
- No word is ever emitted from a partial window.

Optional Feature:
Macro OWNERSHIP_TRACK_EN.
- Defined:
  - Adds ports action_valid (input, 1) and action_in (input, 16), the decision block's action code.
  - Internal owned_q (reset 0) updates when action_valid=1:
    - codes 0x1 and 0x5 -> 0
    - codes 0x4 and 0x6 -> 1
    - codes 0x2, 0x3 and others -> unchanged
  - stock_out[15] uses owned_q; owned_in is ignored.
  - If an action update and a window-completing accept occur in the same cycle, the pre-update owned_q is packed.
- Undefined: no extra ports; bit 15 comes from owned_in.

Test Plan:
- Sliding fill: SLIDING=1, stock_ready=1, owned_in=0, prices 5,10,20 -> one word 0x1554, valid 1 cycle after the third accept; fill_level 1,2,3. Then price 25 -> 0x2A99.
- Clamp/owned: PRICE_W=8, owned_in=1, prices 200,3,1 -> 0xFC61. Price 31 passes unclamped; price 32 clamps to 31.
- Backpressure: hold stock_ready=0 after 0x1554 -> stock_out stable, price_ready=0, offered price not taken. Raise stock_ready with price 25 valid -> 0x2A99 next cycle, no bubble.
- Disjoint mode: SLIDING=0, prices 1,2,3,4,5,6 -> exactly two words 0x0443 and 0x10A6; fill_level returns to 0 after each.
- Flush/reset: prices 7,8 then flush together with price_valid -> price rejected, fill_level=0; next three prices 1,2,3 -> 0x0443. Assert rst_n low mid-fill while a word is pending -> stock_valid=0 and all outputs 0 immediately.
- OWNERSHIP_TRACK_EN: action 0x6 then prices 5,10,20 -> 0x9554. Action 0x5 in the same cycle as the next completing price 25 -> 0xAA99; the following word has bit15=0.
